// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read address/data, write
// enables/addresses/data and the reset-sweep busy flag.
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   init_busy;

  // Pipeline side: issues reads and writes, observes data and busy
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, init_busy
  );

  // Register file side
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the ID/WB stages. Registered reads
// with same-edge write-to-read bypass, x0 hard-wired to zero, and a
// one-register-per-cycle reset sweep that loads the architectural start
// values (sp, gp, zero elsewhere) while init_busy is high.
module regfile_mp #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          NUM_RD  = 2,
  parameter int          NUM_WR  = 2,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h0000_01F4,
  parameter int          GP_IDX  = 3,
  parameter logic [31:0] GP_INIT = 32'h1000_0000
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  // NREGS widened by one bit so the range check also works for 2**AW
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     ptr_reg, ptr_next;
  logic              busy_reg, busy_next;
  logic [NUM_RD*XLEN-1:0] rd_data_reg;
  logic [NUM_RD*XLEN-1:0] rd_next;
  logic [NUM_WR-1:0]      wr_ok;
  logic [XLEN-1:0]        init_val;

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  // Start value for the register currently addressed by the sweep
  always_comb begin
    init_val = '0;
    if (ptr_reg == AW'(SP_IDX))      init_val = XLEN'(SP_INIT);
    else if (ptr_reg == AW'(GP_IDX)) init_val = XLEN'(GP_INIT);
  end

  // FSM state, sweep pointer and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
    end
  end

  // Sweep advances one register per cycle and hands over to RUN after the last
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    busy_next  = busy_reg;
    case (state_reg)
      INIT: begin
        if (ptr_reg == AW'(NREGS - 1)) begin
          state_next = RUN;
          busy_next  = 1'b0;
        end else begin
          ptr_next = ptr_reg + AW'(1);
        end
      end
      RUN: begin
        busy_next = 1'b0;
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
        busy_next  = 1'b1;
      end
    endcase
  end

  // A write port is effective only when enabled and aimed at a real, non-x0 register
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    logic [AW-1:0] waddr;
    assign waddr     = bus.wr_addr[gi*AW +: AW];
    assign wr_ok[gi] = bus.wr_en[gi] && (waddr != '0) && in_range(waddr);
  end

  // Array update: sweep value during INIT, otherwise the write ports with the
  // highest index applied last so it wins on address collisions
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == INIT) begin
        regs[ptr_reg] <= init_val;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k]) regs[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Per read port: zero for x0/out-of-range, else bypassed write data, else stored value
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] val;
    assign raddr = bus.rd_addr[gi*AW +: AW];

    // Same-edge bypass scans ports in ascending order so the highest index wins
    always_comb begin
      val = '0;
      if ((raddr != '0) && in_range(raddr)) begin
        val = regs[raddr];
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] == raddr))
            val = bus.wr_data[k*XLEN +: XLEN];
        end
      end
    end

    assign rd_next[gi*XLEN +: XLEN] = val;
  end

  // Registered read data, held at zero through reset and the sweep
  always_ff @(posedge clk) begin
    if (rst || (state_reg == INIT)) rd_data_reg <= '0;
    else                            rd_data_reg <= rd_next;
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.init_busy = busy_reg;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: reset sweep, readback, bypass, write
// priority, x0, reset during the sweep, and a 16-register / 3-read-port variant.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .AW(4), .NUM_RD(3), .NUM_WR(2)) ifb ();

  regfile_mp #(.NREGS(32), .NUM_RD(2), .NUM_WR(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  regfile_mp #(.NREGS(16), .NUM_RD(3), .NUM_WR(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(int we, int wa0, logic [31:0] wd0, int wa1, logic [31:0] wd1,
                              int ra0, int ra1, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.we = 2'(we);   v.wa0 = 5'(wa0); v.wd0 = wd0; v.wa1 = 5'(wa1); v.wd1 = wd1;
    v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] start_val(int i);
    if (i == 2) return 32'h0000_01F4;
    if (i == 3) return 32'h1000_0000;
    return 32'h0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = '0;
  endtask

  task automatic idle_b();
    ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = '0;
  endtask

  // Counts edges from rst release until init_busy drops, bounded
  task automatic count_busy_a(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (ifa.init_busy && cnt < 200);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    vecs[0]  = mk(0, 0, 0, 0, 0,  2,  3, 32'h0000_01F4, 32'h1000_0000);
    vecs[1]  = mk(0, 0, 0, 0, 0,  1,  4, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 31,  0, 0, 0);
    vecs[3]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  5,  2, 32'hDEAD_BEEF, 32'h0000_01F4);
    vecs[5]  = mk(2, 0, 0, 7, 32'h1234,  5, 7, 32'hDEAD_BEEF, 32'h1234);
    vecs[6]  = mk(0, 0, 0, 0, 0,  7,  7, 32'h1234, 32'h1234);
    vecs[7]  = mk(3, 9, 32'hAAAA, 9, 32'h5555, 9, 9, 32'h5555, 32'h5555);
    vecs[8]  = mk(0, 0, 0, 0, 0,  9,  9, 32'h5555, 32'h5555);
    vecs[9]  = mk(1, 0, 32'hFFFF, 0, 0, 0, 6, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0,  0,  5, 0, 32'hDEAD_BEEF);
    vecs[11] = mk(0, 10, 32'h1, 0, 0, 10, 10, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 10, 10, 0, 0);
    vecs[13] = mk(3, 31, 32'hCAFE_0031, 30, 32'h30, 31, 30, 32'hCAFE_0031, 32'h30);
    vecs[14] = mk(0, 0, 0, 0, 0, 31, 30, 32'hCAFE_0031, 32'h30);

    idle_a();
    idle_b();

    // Reset sweep on the 32-register instance
    rst_a = 1'b1;
    step();
    step();
    check("reset busy", 32'(ifa.init_busy), 32'd1);
    check("reset rd_data", ifa.rd_data[31:0] | ifa.rd_data[63:32], 32'h0);
    rst_a = 1'b0;
    ifa.rd_addr = {5'd3, 5'd2};
    count_busy_a(cnt);
    check("sweep busy cycles", 32'(cnt), 32'd32);
    check("rd_data during sweep", ifa.rd_data[31:0], 32'h0);

    // Every register holds its start value after the sweep
    for (int i = 0; i < 16; i++) begin
      ifa.rd_addr = {5'(i + 16), 5'(i)};
      step();
      check($sformatf("init x%0d", i), ifa.rd_data[31:0], start_val(i));
      check($sformatf("init x%0d", i + 16), ifa.rd_data[63:32], start_val(i + 16));
    end

    // Table: write/readback, bypass, priority, x0, disabled write
    for (int v = 0; v < NV; v++) begin
      ifa.wr_en   = vecs[v].we;
      ifa.wr_addr = {vecs[v].wa1, vecs[v].wa0};
      ifa.wr_data = {vecs[v].wd1, vecs[v].wd0};
      ifa.rd_addr = {vecs[v].ra1, vecs[v].ra0};
      step();
      check($sformatf("vec%0d port0", v), ifa.rd_data[31:0], vecs[v].exp0);
      check($sformatf("vec%0d port1", v), ifa.rd_data[63:32], vecs[v].exp1);
    end
    idle_a();

    // Reset asserted when the sweep pointer reaches 10
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    ifa.rd_addr = {5'd12, 5'd2};
    cnt = 0;
    do begin
      if (cnt == 20) begin
        ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd12}; ifa.wr_data = {32'h0, 32'h77};
      end else begin
        ifa.wr_en = 2'b00;
      end
      step();
      cnt++;
      if (cnt == 5) check("restart sweep read x2", ifa.rd_data[31:0], 32'h0);
    end while (ifa.init_busy && cnt < 200);
    ifa.wr_en = 2'b00;
    check("restart busy cycles", 32'(cnt), 32'd32);
    step();
    check("restart x2", ifa.rd_data[31:0], 32'h0000_01F4);
    check("busy write x12 dropped", ifa.rd_data[63:32], 32'h0);
    ifa.rd_addr = {5'd3, 5'd5};
    step();
    check("sweep clears x5", ifa.rd_data[31:0], 32'h0);
    check("restart x3", ifa.rd_data[63:32], 32'h1000_0000);

    // 16-register, 3-read-port instance
    step();
    check("variant reset busy", 32'(ifb.init_busy), 32'd1);
    rst_b = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (ifb.init_busy && cnt < 200);
    check("variant busy cycles", 32'(cnt), 32'd16);
    ifb.rd_addr = {4'd2, 4'd2, 4'd2};
    step();
    for (int p = 0; p < 3; p++)
      check($sformatf("variant x2 port%0d", p), ifb.rd_data[p*32 +: 32], 32'h0000_01F4);
    ifb.wr_en = 2'b10; ifb.wr_addr = {4'd15, 4'd0}; ifb.wr_data = {32'h0000_0F15, 32'h0};
    ifb.rd_addr = {4'd0, 4'd3, 4'd15};
    step();
    check("variant bypass x15", ifb.rd_data[31:0], 32'h0000_0F15);
    check("variant x3", ifb.rd_data[63:32], 32'h1000_0000);
    ifb.wr_en = 2'b00;
    step();
    check("variant readback x15", ifb.rd_data[31:0], 32'h0000_0F15);
    check("variant x0", ifb.rd_data[95:64], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
